snp_home_agent: RTL and testbench
=================================

// Module: snp_home_agent
// PURPOSE
//  Bus-side home agent: the responder at the far end of a cache's sdreq/sursp and sureq/sdrsp channels.
//  Accepts one down-request (sdreq) from the requesting cache, snoops the single peer cache (sureq/sdrsp),
//  reads/writes a local backing store and returns one up-response (sursp). Blocking: one transaction in flight.
// PARAMETERS
//  SADDR_WIDTH  58    block address width (64-bit PA, 64B blocks)
//  BLK_WIDTH    512   data block width
//  MEM_DEPTH    64    backing-store blocks; indexed by addr[$clog2(MEM_DEPTH)-1:0]
//  SNP_TIMEOUT  255   max cycles in SNP_WAIT before forced completion
// PORTS
//  clk          in  1            clock
//  rst_n        in  1            async active-low reset
//  sdreq_valid  in  1            request valid;  sdreq_ready out 1: accept
//  sdreq_op     in  3            SDREQ_RD/RFO/INV/WB
//  sdreq_addr   in  SADDR_WIDTH  block address;  sdreq_data in BLK_WIDTH: WB data
//  sursp_valid  out 1            response valid; sursp_ready in 1
//  sursp_rsp    out 3            SURSP_OKAY/EX/SH/ERR;  sursp_data out BLK_WIDTH
//  sureq_valid  out 1            snoop valid; sureq_ready in 1
//  sureq_op     out 2            SNP_RD/RFO/INV;  sureq_addr out SADDR_WIDTH
//  sdrsp_valid  in  1            snoop response valid; sdrsp_ready out 1
//  sdrsp_rsp    in  2            SNP_OKAY/HIT/HIT_DIRTY;  sdrsp_data in BLK_WIDTH
//  snp_tmo_err  out 1            sticky: a snoop timed out
// BEHAVIOUR
//  Reset: clk/rst_n async active-low; all valids/readies 0, rsp/op/addr/data 0, snp_tmo_err 0, FSM IDLE, store zeroed.
//  Handshake: transfer on valid&&ready; outbound valid and payload held stable until ready; ready may pulse.
//  FSM: IDLE -> (sdreq xfer; op RD/RFO/INV) SNP_REQ; (WB) MEM; (op 3'b1xx) RSP with SURSP_ERR.
//   SNP_REQ: sureq_valid=1, op RD->SNP_RD, RFO->SNP_RFO, INV->SNP_INV, addr=latched; on xfer -> SNP_WAIT.
//   SNP_WAIT: sdrsp_ready=1; on sdrsp_valid latch rsp/data -> MEM. Counter reaching SNP_TIMEOUT: treat as
//     SNP_OKAY, set snp_tmo_err -> MEM.
//   MEM: one cycle; read store (RD/RFO) or write sdreq_data (WB) -> RSP.
//   RSP: sursp_valid=1; on xfer -> IDLE. Earliest new sdreq accept is cycle after sursp xfer.
//  sdreq_ready=1 only in IDLE; request fields latched at accept, sdreq inputs ignored afterwards.
//  Response table:
//   RD : peer OKAY -> SURSP_EX; HIT/HIT_DIRTY -> SURSP_SH. Data = peer data if HIT_DIRTY else store.
//   RFO: SURSP_EX always; data = peer data if HIT_DIRTY else store.
//   INV: SURSP_OKAY, data 0.   WB: SURSP_OKAY, data 0, store[idx] <= sdreq_data.   Bad op: SURSP_ERR, data 0.
//  Latency (ready always 1): RD/RFO/INV accept cycle 0 -> sureq cyc1 -> sdrsp >=cyc2 -> MEM -> sursp +2; WB sursp cyc2.
//  sdrsp_valid outside SNP_WAIT is ignored (ready 0). Reset mid-transaction aborts, no store write.
//  Timeout counter 8+ bits, clears on SNP_WAIT entry, saturates; snp_tmo_err clears only on reset.
// CONFIGURATION
//  SNP_HOME_IMPLICIT_WB_EN defined: in MEM, sdrsp HIT_DIRTY writes peer data to store[idx] (RD and RFO),
//   keeping store coherent. Undefined: store untouched on dirty snoop; only WB writes the store.
// STRUCTURE
//  cache_pkg: SDREQ_RD=0,RFO=1,INV=2,WB=3; SNP_RD=0,RFO=1,INV=2; SNP_OKAY=0,HIT=1,HIT_DIRTY=2;
//   SURSP_OKAY=0,EX=1,SH=2,ERR=7; home FSM state enum (HOME_IDLE..HOME_RSP).
//  Sub-module snp_home_mem: MEM_DEPTH x BLK_WIDTH store, 1 write port, combinational read, async reset to 0.
// TESTING
//  WB addr 5 data A -> sursp OKAY at cyc2, no sureq; then RD addr 5, peer OKAY -> sursp EX, data A.
//  RD addr 9, peer HIT_DIRTY data B -> sursp SH data B; next RD addr 9 peer OKAY -> B with _EN, 0 without.
//  RFO addr 3, peer HIT -> sureq SNP_RFO addr 3; sursp EX with store data.
//  INV, peer never answers -> after SNP_TIMEOUT cycles sursp OKAY, snp_tmo_err=1 until reset.
//  sursp_ready held 0 for 10 cycles -> sursp_valid/rsp/data stable, sdreq_ready stays 0.
//  sdreq_op=3'b101 -> sursp ERR, no sureq; rst_n low in SNP_WAIT -> all valids 0, IDLE.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared encodings for the snooping home agent: request/snoop/response opcodes and home FSM states.
package cache_pkg;

    typedef enum logic [2:0] {
        SDREQ_RD  = 3'd0,
        SDREQ_RFO = 3'd1,
        SDREQ_INV = 3'd2,
        SDREQ_WB  = 3'd3
    } sdreq_op_e;

    typedef enum logic [1:0] {
        SNP_RD  = 2'd0,
        SNP_RFO = 2'd1,
        SNP_INV = 2'd2
    } snp_op_e;

    typedef enum logic [1:0] {
        SNP_OKAY      = 2'd0,
        SNP_HIT       = 2'd1,
        SNP_HIT_DIRTY = 2'd2
    } snp_rsp_e;

    typedef enum logic [2:0] {
        SURSP_OKAY = 3'd0,
        SURSP_EX   = 3'd1,
        SURSP_SH   = 3'd2,
        SURSP_ERR  = 3'd7
    } sursp_rsp_e;

    typedef enum logic [2:0] {
        HOME_IDLE,
        HOME_SNP_REQ,
        HOME_SNP_WAIT,
        HOME_MEM,
        HOME_RSP
    } home_state_e;

    // Snoop opcode issued to the peer for a given down-request.
    function automatic snp_op_e snp_op_of(input logic [2:0] op);
        case (op)
            SDREQ_RFO: return SNP_RFO;
            SDREQ_INV: return SNP_INV;
            default:   return SNP_RD;
        endcase
    endfunction

endpackage

// File: rtl/snp_home_mem.sv
// Backing store for the home agent: one write port, combinational read, contents cleared on reset.
module snp_home_mem #(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 512,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: the store is flop-based so it can be cleared on reset; a RAM macro would need an init sweep instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/snp_home_agent.sv
// Blocking home agent: accepts one sdreq, snoops the peer, accesses the store, returns one sursp.
// Define SNP_HOME_IMPLICIT_WB_EN to write dirty snoop data back into the store on RD/RFO.
module snp_home_agent
    import cache_pkg::*;
#(
    parameter int SADDR_WIDTH = 58,
    parameter int BLK_WIDTH   = 512,
    parameter int MEM_DEPTH   = 64,
    parameter int SNP_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sdreq_valid,
    output logic                   sdreq_ready,
    input  logic [2:0]             sdreq_op,
    input  logic [SADDR_WIDTH-1:0] sdreq_addr,
    input  logic [BLK_WIDTH-1:0]   sdreq_data,
    output logic                   sursp_valid,
    input  logic                   sursp_ready,
    output logic [2:0]             sursp_rsp,
    output logic [BLK_WIDTH-1:0]   sursp_data,
    output logic                   sureq_valid,
    input  logic                   sureq_ready,
    output logic [1:0]             sureq_op,
    output logic [SADDR_WIDTH-1:0] sureq_addr,
    input  logic                   sdrsp_valid,
    output logic                   sdrsp_ready,
    input  logic [1:0]             sdrsp_rsp,
    input  logic [BLK_WIDTH-1:0]   sdrsp_data,
    output logic                   snp_tmo_err
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = ($clog2(SNP_TIMEOUT + 1) > 8) ? $clog2(SNP_TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(SNP_TIMEOUT);

    home_state_e            state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [SADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BLK_WIDTH-1:0]   wdata_q, wdata_d;
    logic [1:0]             snp_rsp_q, snp_rsp_d;
    logic [BLK_WIDTH-1:0]   snp_data_q, snp_data_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tmo_err_q, tmo_err_d;
    logic                   sdreq_ready_q, sdreq_ready_d;
    logic [2:0]             rsp_q, rsp_d;
    logic [BLK_WIDTH-1:0]   rdata_q, rdata_d;

    logic                   mem_we;
    logic [BLK_WIDTH-1:0]   mem_wdata;
    logic [BLK_WIDTH-1:0]   mem_rdata;
    logic [IDX_W-1:0]       mem_idx;
    logic                   snp_dirty;

    assign mem_idx   = addr_q[IDX_W-1:0];
    assign snp_dirty = (snp_rsp_q == SNP_HIT_DIRTY);

    snp_home_mem #(
        .DEPTH(MEM_DEPTH),
        .WIDTH(BLK_WIDTH)
    ) u_mem (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (mem_we),
        .waddr(mem_idx),
        .wdata(mem_wdata),
        .raddr(mem_idx),
        .rdata(mem_rdata)
    );

    // NOTE: every signal gets its default first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        snp_rsp_d  = snp_rsp_q;
        snp_data_d = snp_data_q;
        cnt_d      = cnt_q;
        tmo_err_d  = tmo_err_q;
        rsp_d      = rsp_q;
        rdata_d    = rdata_q;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        unique case (state_q)
            HOME_IDLE: begin
                if (sdreq_valid && sdreq_ready_q) begin
                    op_d    = sdreq_op;
                    addr_d  = sdreq_addr;
                    wdata_d = sdreq_data;
                    if (sdreq_op[2]) begin
                        rsp_d   = SURSP_ERR;
                        rdata_d = '0;
                        state_d = HOME_RSP;
                    end else if (sdreq_op == SDREQ_WB) begin
                        state_d = HOME_MEM;
                    end else begin
                        state_d = HOME_SNP_REQ;
                    end
                end
            end

            HOME_SNP_REQ: begin
                if (sureq_ready) begin
                    cnt_d   = '0;
                    state_d = HOME_SNP_WAIT;
                end
            end

            HOME_SNP_WAIT: begin
                // A real answer on the same cycle as the limit wins over the timeout.
                if (sdrsp_valid) begin
                    snp_rsp_d  = sdrsp_rsp;
                    snp_data_d = sdrsp_data;
                    state_d    = HOME_MEM;
                end else if (cnt_q >= TMO_LIMIT) begin
                    snp_rsp_d  = SNP_OKAY;
                    snp_data_d = '0;
                    tmo_err_d  = 1'b1;
                    state_d    = HOME_MEM;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HOME_MEM: begin
                rsp_d   = SURSP_OKAY;
                rdata_d = '0;
                case (op_q)
                    SDREQ_RD: begin
                        rsp_d   = (snp_rsp_q == SNP_OKAY) ? SURSP_EX : SURSP_SH;
                        rdata_d = snp_dirty ? snp_data_q : mem_rdata;
                    end
                    SDREQ_RFO: begin
                        rsp_d   = SURSP_EX;
                        rdata_d = snp_dirty ? snp_data_q : mem_rdata;
                    end
                    SDREQ_WB: begin
                        mem_we    = 1'b1;
                        mem_wdata = wdata_q;
                    end
                    default: ;
                endcase
`ifdef SNP_HOME_IMPLICIT_WB_EN
                if (snp_dirty && (op_q == SDREQ_RD || op_q == SDREQ_RFO)) begin
                    mem_we    = 1'b1;
                    mem_wdata = snp_data_q;
                end
`endif
                state_d = HOME_RSP;
            end

            HOME_RSP: begin
                if (sursp_ready) begin
                    state_d = HOME_IDLE;
                end
            end

            default: state_d = HOME_IDLE;
        endcase

        sdreq_ready_d = (state_d == HOME_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HOME_IDLE;
            op_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            snp_rsp_q     <= '0;
            snp_data_q    <= '0;
            cnt_q         <= '0;
            tmo_err_q     <= 1'b0;
            sdreq_ready_q <= 1'b0;
            rsp_q         <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            snp_rsp_q     <= snp_rsp_d;
            snp_data_q    <= snp_data_d;
            cnt_q         <= cnt_d;
            tmo_err_q     <= tmo_err_d;
            sdreq_ready_q <= sdreq_ready_d;
            rsp_q         <= rsp_d;
            rdata_q       <= rdata_d;
        end
    end

    assign sdreq_ready = sdreq_ready_q;
    assign sureq_valid = (state_q == HOME_SNP_REQ);
    assign sureq_op    = sureq_valid ? snp_op_of(op_q) : SNP_RD;
    assign sureq_addr  = sureq_valid ? addr_q : '0;
    assign sdrsp_ready = (state_q == HOME_SNP_WAIT);
    assign sursp_valid = (state_q == HOME_RSP);
    assign sursp_rsp   = rsp_q;
    assign sursp_data  = rdata_q;
    assign snp_tmo_err = tmo_err_q;

endmodule

// File: tb/tb_snp_home_agent.sv
// Randomized scoreboard bench for snp_home_agent: a behavioural home/peer model predicts every
// sursp and sureq, and a free-running monitor compares them as the DUT presents them.
module tb_snp_home_agent;

    localparam int SADDR_WIDTH = 58;
    localparam int BLK_WIDTH   = 512;
    localparam int MEM_DEPTH   = 64;
    localparam int SNP_TIMEOUT = 255;

    logic                   clk;
    logic                   rst_n;
    logic                   sdreq_valid;
    logic                   sdreq_ready;
    logic [2:0]             sdreq_op;
    logic [SADDR_WIDTH-1:0] sdreq_addr;
    logic [BLK_WIDTH-1:0]   sdreq_data;
    logic                   sursp_valid;
    logic                   sursp_ready;
    logic [2:0]             sursp_rsp;
    logic [BLK_WIDTH-1:0]   sursp_data;
    logic                   sureq_valid;
    logic                   sureq_ready;
    logic [1:0]             sureq_op;
    logic [SADDR_WIDTH-1:0] sureq_addr;
    logic                   sdrsp_valid;
    logic                   sdrsp_ready;
    logic [1:0]             sdrsp_rsp;
    logic [BLK_WIDTH-1:0]   sdrsp_data;
    logic                   snp_tmo_err;

    snp_home_agent #(
        .SADDR_WIDTH(SADDR_WIDTH),
        .BLK_WIDTH  (BLK_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .SNP_TIMEOUT(SNP_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sdreq_valid(sdreq_valid),
        .sdreq_ready(sdreq_ready),
        .sdreq_op   (sdreq_op),
        .sdreq_addr (sdreq_addr),
        .sdreq_data (sdreq_data),
        .sursp_valid(sursp_valid),
        .sursp_ready(sursp_ready),
        .sursp_rsp  (sursp_rsp),
        .sursp_data (sursp_data),
        .sureq_valid(sureq_valid),
        .sureq_ready(sureq_ready),
        .sureq_op   (sureq_op),
        .sureq_addr (sureq_addr),
        .sdrsp_valid(sdrsp_valid),
        .sdrsp_ready(sdrsp_ready),
        .sdrsp_rsp  (sdrsp_rsp),
        .sdrsp_data (sdrsp_data),
        .snp_tmo_err(snp_tmo_err)
    );

    typedef struct {
        logic [2:0]           rsp;
        logic [BLK_WIDTH-1:0] data;
    } exp_rsp_t;

    typedef struct {
        logic [1:0]             op;
        logic [SADDR_WIDTH-1:0] addr;
    } exp_snp_t;

    exp_rsp_t             rsp_q[$];
    exp_snp_t             snp_q[$];
    logic [BLK_WIDTH-1:0] model_mem [MEM_DEPTH];
    int                   checks = 0;
    int                   errors = 0;
    int                   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [BLK_WIDTH-1:0] act, input logic [BLK_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic [BLK_WIDTH-1:0] rand_blk();
        logic [BLK_WIDTH-1:0] b;
        for (int i = 0; i < BLK_WIDTH / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [SADDR_WIDTH-1:0] rand_addr(input int idx);
        logic [63:0] a;
        a = {$urandom, $urandom};
        a[5:0] = idx[5:0];
        return a[SADDR_WIDTH-1:0];
    endfunction

    // Monitor: pops the scoreboard on every sursp/sureq transfer and watches held responses.
    initial begin : monitor
        logic                 stall;
        logic [2:0]           prev_rsp;
        logic [BLK_WIDTH-1:0] prev_data;
        exp_rsp_t             e;
        exp_snp_t             s;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                check("sursp_valid_held", sursp_valid, 1'b1);
                check("sursp_rsp_held", sursp_rsp, prev_rsp);
                check("sursp_data_held", sursp_data, prev_data);
            end
            if (sursp_valid) check("sdreq_ready_busy", sdreq_ready, 1'b0);
            if (sursp_valid && sursp_ready) begin
                if (rsp_q.size() == 0) begin
                    expired("unexpected_sursp");
                end else begin
                    e = rsp_q.pop_front();
                    check("sursp_rsp", sursp_rsp, e.rsp);
                    check("sursp_data", sursp_data, e.data);
                end
            end
            stall     = sursp_valid && !sursp_ready;
            prev_rsp  = sursp_rsp;
            prev_data = sursp_data;
            if (sureq_valid && sureq_ready) begin
                if (snp_q.size() == 0) begin
                    expired("unexpected_sureq");
                end else begin
                    s = snp_q.pop_front();
                    check("sureq_op", sureq_op, s.op);
                    check("sureq_addr", sureq_addr, s.addr);
                end
            end
        end
    end

    // Asserts reset from a posedge+1 point, checks the quiescent outputs, clears the model, releases.
    task automatic apply_reset();
        rst_n       = 1'b0;
        sdreq_valid = 1'b0;
        sdrsp_valid = 1'b0;
        sursp_ready = 1'b0;
        @(negedge clk);
        check("rst_sdreq_ready", sdreq_ready, 1'b0);
        check("rst_sursp_valid", sursp_valid, 1'b0);
        check("rst_sureq_valid", sureq_valid, 1'b0);
        check("rst_sdrsp_ready", sdrsp_ready, 1'b0);
        check("rst_sursp_rsp", sursp_rsp, 3'd0);
        check("rst_sursp_data", sursp_data, '0);
        check("rst_sureq_addr", sureq_addr, '0);
        check("rst_tmo_err", snp_tmo_err, 1'b0);
        rsp_q.delete();
        snp_q.delete();
        for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One complete transaction: predict, drive sdreq, play the peer, drain sursp, check latency.
    task automatic do_txn(input logic [2:0] op, input logic [SADDR_WIDTH-1:0] addr,
                          input logic [BLK_WIDTH-1:0] wdata, input logic [1:0] prsp,
                          input logic [BLK_WIDTH-1:0] pdata, input int pdly, input bit answer,
                          input int rdly, input bit abort);
        exp_rsp_t e;
        exp_snp_t s;
        int       idx;
        int       t0;
        int       n;
        int       lat;
        bit       snooped;
        logic [1:0] eff;

        idx     = int'(addr[5:0]);
        snooped = !op[2] && (op != 3'd3);
        eff     = answer ? prsp : 2'd0;
        e.rsp   = 3'd0;
        e.data  = '0;
        if (op[2]) begin
            e.rsp = 3'd7;
            lat   = 1;
        end else if (op == 3'd3) begin
            model_mem[idx] = wdata;
            lat = 2;
        end else begin
            lat = answer ? 4 + pdly : 4 + SNP_TIMEOUT;
            if (op != 3'd2) begin
                e.rsp  = (op == 3'd1 || eff == 2'd0) ? 3'd1 : 3'd2;
                e.data = (eff == 2'd2) ? pdata : model_mem[idx];
`ifdef SNP_HOME_IMPLICIT_WB_EN
                if (eff == 2'd2) model_mem[idx] = pdata;
`endif
            end
            s.op   = (op == 3'd0) ? 2'd0 : (op == 3'd1) ? 2'd1 : 2'd2;
            s.addr = addr;
            snp_q.push_back(s);
        end
        rsp_q.push_back(e);

        @(posedge clk);
        #1;
        sdreq_valid = 1'b1;
        sdreq_op    = op;
        sdreq_addr  = addr;
        sdreq_data  = wdata;
        sursp_ready = (rdly == 0);
        n = 0;
        forever begin
            @(negedge clk);
            if (sdreq_ready) break;
            if (++n > 50) begin
                expired("sdreq_accept");
                return;
            end
        end
        t0 = cyc;
        @(posedge clk);
        #1;
        sdreq_valid = 1'b0;
        sdreq_op    = 3'($urandom);
        sdreq_addr  = rand_addr($urandom_range(0, 63));
        sdreq_data  = rand_blk();

        if (snooped) begin
            n = 0;
            forever begin
                @(negedge clk);
                if (sureq_valid) break;
                if (++n > 50) begin
                    expired("sureq_wait");
                    return;
                end
            end
            @(posedge clk);
            if (abort) begin
                @(posedge clk);
                #1;
                apply_reset();
                return;
            end
            if (answer) begin
                repeat (pdly) @(posedge clk);
                #1;
                sdrsp_valid = 1'b1;
                sdrsp_rsp   = prsp;
                sdrsp_data  = pdata;
                n = 0;
                forever begin
                    @(negedge clk);
                    if (sdrsp_ready) break;
                    if (++n > 50) begin
                        expired("sdrsp_accept");
                        sdrsp_valid = 1'b0;
                        return;
                    end
                end
                @(posedge clk);
                #1;
                sdrsp_valid = 1'b0;
                sdrsp_rsp   = 2'($urandom);
                sdrsp_data  = rand_blk();
            end
        end

        n = 0;
        forever begin
            if (sursp_valid) break;
            @(negedge clk);
            if (sursp_valid) break;
            if (++n > SNP_TIMEOUT + 50) begin
                expired("sursp_wait");
                return;
            end
        end
        check("sursp_latency", cyc - t0, lat);
        if (rdly > 0) begin
            repeat (rdly) @(negedge clk);
            @(posedge clk);
            #1 sursp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1 sursp_ready = 1'b0;
    endtask

    initial begin : stim
        logic [BLK_WIDTH-1:0] blk_a;
        logic [BLK_WIDTH-1:0] blk_b;
        logic [2:0]           op;
        int                   r;

        rst_n       = 1'b0;
        sdreq_valid = 1'b0;
        sdreq_op    = '0;
        sdreq_addr  = '0;
        sdreq_data  = '0;
        sursp_ready = 1'b0;
        sureq_ready = 1'b1;
        sdrsp_valid = 1'b0;
        sdrsp_rsp   = '0;
        sdrsp_data  = '0;
        blk_a = rand_blk();
        blk_b = rand_blk();

        repeat (2) @(posedge clk);
        #1;
        apply_reset();
        repeat (2) @(negedge clk);
        check("idle_sdreq_ready", sdreq_ready, 1'b1);

        // Stray snoop answer while idle must be ignored.
        @(posedge clk);
        #1;
        sdrsp_valid = 1'b1;
        sdrsp_rsp   = 2'd2;
        sdrsp_data  = rand_blk();
        @(negedge clk);
        check("idle_sdrsp_ready", sdrsp_ready, 1'b0);
        @(posedge clk);
        #1 sdrsp_valid = 1'b0;

        do_txn(3'd3, 58'd5, blk_a, 2'd0, '0, 0, 1'b1, 0, 1'b0);
        do_txn(3'd0, 58'd5, '0, 2'd0, rand_blk(), 0, 1'b1, 0, 1'b0);
        do_txn(3'd0, 58'd9, '0, 2'd2, blk_b, 0, 1'b1, 0, 1'b0);
        do_txn(3'd0, 58'd9, '0, 2'd0, rand_blk(), 1, 1'b1, 0, 1'b0);
        do_txn(3'd1, 58'd3, '0, 2'd1, rand_blk(), 2, 1'b1, 0, 1'b0);
        do_txn(3'd0, rand_addr(7), '0, 2'd1, rand_blk(), 0, 1'b1, 10, 1'b0);
        do_txn(3'd5, rand_addr(1), rand_blk(), 2'd0, '0, 0, 1'b1, 0, 1'b0);

        check("tmo_err_before", snp_tmo_err, 1'b0);
        do_txn(3'd2, rand_addr(2), '0, 2'd0, '0, 0, 1'b0, 0, 1'b0);
        check("tmo_err_set", snp_tmo_err, 1'b1);
        do_txn(3'd1, rand_addr(4), '0, 2'd2, rand_blk(), 0, 1'b1, 1, 1'b0);
        check("tmo_err_sticky", snp_tmo_err, 1'b1);

        do_txn(3'd0, rand_addr(6), '0, 2'd0, '0, 0, 1'b1, 0, 1'b1);
        repeat (2) @(negedge clk);
        check("post_rst_sdreq_ready", sdreq_ready, 1'b1);
        check("post_rst_tmo_err", snp_tmo_err, 1'b0);
        do_txn(3'd0, 58'd5, '0, 2'd0, rand_blk(), 0, 1'b1, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 2)      op = 3'd0;
            else if (r <= 4) op = 3'd1;
            else if (r == 5) op = 3'd2;
            else if (r <= 8) op = 3'd3;
            else             op = 3'(4 + $urandom_range(0, 3));
            do_txn(op, rand_addr($urandom_range(0, 7)), rand_blk(), 2'($urandom_range(0, 2)),
                   rand_blk(), $urandom_range(0, 3), 1'b1, $urandom_range(0, 3), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("rsp_queue_empty", rsp_q.size(), 0);
        check("snp_queue_empty", snp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
